// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared types and constants for the seq_divider block.
//   state_t       : controller states (IDLE, PREP, RUN, FIX, DONE)
//   calc_steps()  : number of RUN iterations for a given width / radix
//   DBZ_QUOTIENT  : quotient pattern returned on divide-by-zero (all ones);
//                   users slice the low WIDTH bits.
// -----------------------------------------------------------------------------
package divider_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int MAX_WIDTH = 256;

  localparam logic [MAX_WIDTH-1:0] DBZ_QUOTIENT = '1;

  function automatic int calc_steps(input int width, input int bits_per_cycle);
    return width / bits_per_cycle;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   partial_rem : running remainder, always < divisor on entry
//   in_bit      : next dividend bit shifted in at the LSB
//   divisor     : divisor magnitude (non-zero)
//   next_rem    : remainder after this step
//   q_bit       : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] partial_rem,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0]   trial;
  logic [WIDTH+1:0] diff;
  logic             unused_top_bits;

  assign trial = {partial_rem, in_bit};
  // One extra MSB so the borrow of trial - divisor is visible.
  assign diff  = {1'b0, trial} - {2'b00, divisor};
  assign q_bit = ~diff[WIDTH+1];

  // Since partial_rem < divisor, trial < 2*divisor: the kept value always
  // fits in WIDTH bits, so the top bits of trial/diff never matter.
  assign next_rem = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

  assign unused_top_bits = diff[WIDTH] ^ trial[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle restoring integer divider, one division in flight at a time.
// Retires BITS_PER_CYCLE quotient bits per RUN cycle.
//
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN
//   defined   : in_signed honoured (two's complement operands, quotient
//               truncated toward zero, remainder takes the dividend's sign)
//   undefined : operands always unsigned; PREP/FIX only pass data through
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid / in_ready   : request handshake (in_ready high only in IDLE)
//   in_signed             : signed request, sampled at accept
//   dividend, divisor     : operands, sampled at accept
//   out_valid / out_ready : result handshake (result held until accepted)
//   quotient, remainder   : result
//   div_by_zero           : result produced with divisor == 0
//                           (quotient all ones, remainder = dividend)
// -----------------------------------------------------------------------------
module seq_divider
  import divider_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int STEPS = calc_steps(WIDTH, BITS_PER_CYCLE);
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] dvd_raw;   // dividend as accepted
  logic [WIDTH-1:0] dsr_raw;   // divisor as accepted
  logic [WIDTH-1:0] q_r;       // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] rem_r;     // partial remainder
  logic [WIDTH-1:0] d_r;       // divisor magnitude

  logic [WIDTH-1:0] prep_q;
  logic [WIDTH-1:0] prep_d;
  logic [WIDTH-1:0] fix_q;
  logic [WIDTH-1:0] fix_r;

  logic             dsr_zero;

  logic [WIDTH-1:0]          rem_chain [0:BITS_PER_CYCLE];
  logic [BITS_PER_CYCLE-1:0] q_bits;
  logic [WIDTH-1:0]          q_shift;
  logic [WIDTH-1:0]          q_next;

  assign in_ready = (state == IDLE);
  assign dsr_zero = (dsr_raw == '0);

  // ---- PREP / FIX sign handling ----------------------------------------------
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic sgn_r;
  logic neg_q_r;
  logic neg_r_r;
  logic signed [WIDTH-1:0] dvd_s;
  logic signed [WIDTH-1:0] dsr_s;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return {WIDTH{1'b0}} - v;
  endfunction

  // Magnitude in WIDTH-bit unsigned form; MIN_INT maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    return (v < 0) ? negate(v) : v;
  endfunction

  assign dvd_s = dvd_raw;
  assign dsr_s = dsr_raw;

  always_comb begin
    prep_q = sgn_r ? magnitude(dvd_s) : dvd_raw;
    prep_d = sgn_r ? magnitude(dsr_s) : dsr_raw;
    fix_q  = neg_q_r ? negate(q_r) : q_r;
    fix_r  = neg_r_r ? negate(rem_r) : rem_r;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sgn_r   <= 1'b0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        sgn_r <= in_signed;
      end
      if (state == PREP) begin
        neg_q_r <= sgn_r & (dvd_raw[WIDTH-1] ^ dsr_raw[WIDTH-1]);
        neg_r_r <= sgn_r & dvd_raw[WIDTH-1];
      end
    end
  end
`else
  logic unused_in_signed;

  assign unused_in_signed = in_signed;

  always_comb begin
    prep_q = dvd_raw;
    prep_d = dsr_raw;
    fix_q  = q_r;
    fix_r  = rem_r;
  end
`endif

  // ---- RUN: cascade of restoring steps ---------------------------------------
  assign rem_chain[0] = rem_r;

  for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
    div_step #(
      .WIDTH(WIDTH)
    ) u_step (
      .partial_rem(rem_chain[k]),
      .in_bit     (q_r[WIDTH-1-k]),
      .divisor    (d_r),
      .next_rem   (rem_chain[k+1]),
      .q_bit      (q_bits[BITS_PER_CYCLE-1-k])
    );
  end

  assign q_shift = q_r << BITS_PER_CYCLE;
  assign q_next  = q_shift | WIDTH'(q_bits);

  // ---- controller and registered outputs -------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd_raw     <= '0;
      dsr_raw     <= '0;
      q_r         <= '0;
      rem_r       <= '0;
      d_r         <= '0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd_raw <= dividend;
            dsr_raw <= divisor;
            state   <= PREP;
          end
        end
        PREP: begin
          q_r   <= prep_q;
          d_r   <= prep_d;
          rem_r <= '0;
          cnt   <= CNT_W'(STEPS - 1);
          state <= dsr_zero ? FIX : RUN;
        end
        RUN: begin
          q_r   <= q_next;
          rem_r <= rem_chain[BITS_PER_CYCLE];
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        FIX: begin
          if (dsr_zero) begin
            quotient    <= DBZ_QUOTIENT[WIDTH-1:0];
            remainder   <= dvd_raw;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= fix_q;
            remainder   <= fix_r;
            div_by_zero <= 1'b0;
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid1, in_valid4;
  logic        in_signed;
  logic [31:0] dividend, divisor;
  logic        out_ready1, out_ready4;

  logic        in_ready1, out_valid1, dbz1;
  logic [31:0] q1, r1;
  logic        in_ready4, out_valid4, dbz4;
  logic [31:0] q4, r4;

  logic        sel4;
  logic        ir_s, ov_s, dz_s;
  logic [31:0] q_s, r_s;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vt[$];

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_signed(in_signed), .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .quotient(q1), .remainder(r1), .div_by_zero(dbz1)
  );

  seq_divider #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_signed(in_signed), .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .quotient(q4), .remainder(r4), .div_by_zero(dbz4)
  );

  assign ir_s = sel4 ? in_ready4  : in_ready1;
  assign ov_s = sel4 ? out_valid4 : out_valid1;
  assign q_s  = sel4 ? q4 : q1;
  assign r_s  = sel4 ? r4 : r1;
  assign dz_s = sel4 ? dbz4 : dbz1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 input int lat_norm);
    exp_t   e;
    longint sa, sd;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1; e.lat = 2;
    end else begin
      e.dz = 1'b0; e.lat = lat_norm;
      if (s && SGN) begin
        sa = longint'($signed(a));
        sd = longint'($signed(b));
        e.q = 32'(sa / sd);
        e.r = 32'(sa % sd);
      end else begin
        e.q = a / b;
        e.r = a % b;
      end
    end
    return e;
  endfunction

  task automatic set_valid(input logic v);
    if (sel4) in_valid4 = v; else in_valid1 = v;
  endtask

  task automatic set_ready(input logic v);
    if (sel4) out_ready4 = v; else out_ready1 = v;
  endtask

  // Drives one request at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input exp_t e);
    int n = 0;
    while (!ir_s && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) chk("in_ready_timeout", {63'd0, ir_s}, 64'd1);
    dividend = a; divisor = b; in_signed = s;
    set_valid(1'b1);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    set_valid(1'b0);
  endtask

  // Counts edges after the accept edge until out_valid is seen high.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!ov_s && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic collect(input int lat, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_latency"}, 64'(lat), 64'(e.lat));
    chk({tag, "_out_valid"}, {63'd0, ov_s}, 64'd1);
    chk({tag, "_quotient"}, {32'd0, q_s}, {32'd0, e.q});
    chk({tag, "_remainder"}, {32'd0, r_s}, {32'd0, e.r});
    chk({tag, "_div_by_zero"}, {63'd0, dz_s}, {63'd0, e.dz});
    set_ready(1'b1);
    @(posedge clk);
    @(negedge clk);
    set_ready(1'b0);
    chk({tag, "_in_ready_after"}, {63'd0, ir_s}, 64'd1);
    chk({tag, "_out_valid_after"}, {63'd0, ov_s}, 64'd0);
  endtask

  task automatic run_req(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz,
                         input string tag);
    exp_t e;
    int   lat;
    e.q = eq; e.r = er; e.dz = edz;
    e.lat = edz ? 2 : (sel4 ? 10 : 34);
    issue(a, b, s, e);
    wait_out(lat);
    collect(lat, tag);
  endtask

  initial begin
    exp_t        e;
    int          lat;
    logic [31:0] ra, rb;
    logic        rs;

    reset = 1'b1;
    in_valid1 = 1'b0; in_valid4 = 1'b0;
    out_ready1 = 1'b0; out_ready4 = 1'b0;
    in_signed = 1'b0; dividend = '0; divisor = '0;
    sel4 = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_in_ready", {63'd0, in_ready1}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid1}, 64'd0);
    chk("rst_quotient", {32'd0, q1}, 64'd0);
    chk("rst_remainder", {32'd0, r1}, 64'd0);
    chk("rst_div_by_zero", {63'd0, dbz1}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // ---- table-driven vectors ----
    vt.push_back('{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0});
    vt.push_back('{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1});
    vt.push_back('{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0});
    vt.push_back('{32'd0,          32'd9,          1'b0, 32'd0,          32'd0,          1'b0});
    vt.push_back('{32'd7,          32'd100,        1'b0, 32'd0,          32'd7,          1'b0});
    vt.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0,          1'b0});
    vt.push_back('{32'h8000_0000,  32'd3,          1'b0, 32'h2AAA_AAAA,  32'd2,          1'b0});
    vt.push_back('{32'd0,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b1});
`ifdef SEQ_DIVIDER_SIGNED_EN
    vt.push_back('{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0});
    vt.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0});
    vt.push_back('{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0});
    vt.push_back('{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF,  1'b0});
    vt.push_back('{32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1});
    vt.push_back('{32'h8000_0000,  32'd1,          1'b1, 32'h8000_0000,  32'd0,          1'b0});
    vt.push_back('{32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1,          1'b0});
`else
    vt.push_back('{32'hFFFF_FFF9,  32'd2,          1'b1, 32'h7FFF_FFFC,  32'd1,          1'b0});
    vt.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'd0,          32'h8000_0000,  1'b0});
`endif
    foreach (vt[i]) begin
      run_req(vt[i].a, vt[i].b, vt[i].s, vt[i].q, vt[i].r, vt[i].dz, $sformatf("vec%0d", i));
    end

    // ---- random vectors against the behavioural model ----
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      e  = model(ra, rb, rs, 34);
      run_req(ra, rb, rs, e.q, e.r, e.dz, $sformatf("rnd%0d", i));
    end

    // ---- back-pressure in DONE with a pending request ----
    e = model(32'd100, 32'd7, 1'b0, 34);
    issue(32'd100, 32'd7, 1'b0, e);
    wait_out(lat);
    dividend = 32'd9; divisor = 32'd3; in_signed = 1'b0;
    in_valid1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp_out_valid%0d", i), {63'd0, out_valid1}, 64'd1);
      chk($sformatf("bp_quotient%0d", i), {32'd0, q1}, 64'd14);
      chk($sformatf("bp_remainder%0d", i), {32'd0, r1}, 64'd2);
      chk($sformatf("bp_in_ready%0d", i), {63'd0, in_ready1}, 64'd0);
    end
    collect(lat, "bp_first");
    e = model(32'd9, 32'd3, 1'b0, 34);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    chk("bp_accepted", {63'd0, in_ready1}, 64'd0);
    in_valid1 = 1'b0;
    wait_out(lat);
    collect(lat, "bp_second");

    // ---- reset mid-RUN ----
    e = model(32'd1000, 32'd7, 1'b0, 34);
    issue(32'd1000, 32'd7, 1'b0, e);
    repeat (11) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_in_ready", {63'd0, in_ready1}, 64'd1);
    chk("abort_out_valid", {63'd0, out_valid1}, 64'd0);
    chk("abort_quotient", {32'd0, q1}, 64'd0);
    chk("abort_remainder", {32'd0, r1}, 64'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_result", {63'd0, out_valid1}, 64'd0);
    run_req(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, "after_abort");

    // ---- reset while holding a result in DONE ----
    e = model(32'd100, 32'd7, 1'b0, 34);
    issue(32'd100, 32'd7, 1'b0, e);
    wait_out(lat);
    #1 reset = 1'b1;
    #1;
    chk("done_rst_out_valid", {63'd0, out_valid1}, 64'd0);
    chk("done_rst_quotient", {32'd0, q1}, 64'd0);
    chk("done_rst_remainder", {32'd0, r1}, 64'd0);
    chk("done_rst_in_ready", {63'd0, in_ready1}, 64'd1);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // ---- four bits per cycle ----
    sel4 = 1'b1;
    run_req(32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF, 1'b0, "r4_ff_div_10");
    run_req(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, "r4_100_div_7");
    run_req(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, "r4_div0");
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      rs = 1'($urandom_range(0, 1));
      e  = model(ra, rb, rs, 10);
      run_req(ra, rb, rs, e.q, e.r, e.dz, $sformatf("r4_rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
